line_mem_responder: RTL and testbench

Responder end of the cache's physical-memory interface: accepts a whole-line (128-bit) read or write request from the cache side (`pmem_*`) and services it as eight 16-bit beats on a word-wide SRAM-style port. Sits between the top-level cache (L2/eight-way) and off-chip/backing memory. `pmem_resp` pulses for one cycle on completion.

---
 rtl/cache_types.sv | 20 ++
 rtl/line_beat_buffer.sv | 39 +++
 rtl/line_mem_responder.sv | 140 ++++++++++++++
 tb/tb_line_mem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// Shared types for the cache's physical-memory side: word/line typedefs,
// beat geometry and the line responder's state encoding.
package cache_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] cache_line;

    // A line moves as eight 16-bit beats, word b at line bits [16b+15:16b].
    localparam int line_beats = 8;
    localparam int beat_width = 16;
    typedef logic [2:0] beat_index;

    // Responder FSM states; the encoding is also what dbg_state reports.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RESP  = 2'd2
    } responder_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Line buffer for the responder: a 128-bit register that loads a whole line
// in parallel, updates one 16-bit beat at a time, and muxes out one beat.
module line_beat_buffer
    import cache_types::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_en,
    input  logic [127:0] load_data,
    input  logic         wr_en,
    input  logic [2:0]   wr_beat,
    input  logic [15:0]  wr_data,
    input  logic [2:0]   rd_beat,
    output logic [15:0]  rd_data,
    output logic [127:0] line_out
);

    cache_line line_q;
    beat_index wr_idx;
    beat_index rd_idx;

    assign wr_idx = wr_beat;
    assign rd_idx = rd_beat;

    // Whole-line load takes priority over a single-beat update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q <= '0;
        end else if (load_en) begin
            line_q <= load_data;
        end else if (wr_en) begin
            line_q[{wr_idx, 4'b0000} +: 16] <= wr_data;
        end
    end

    assign rd_data  = line_q[{rd_idx, 4'b0000} +: 16];
    assign line_out = line_q;

endmodule

// File: rtl/line_mem_responder.sv
// Responder end of the cache's physical-memory interface. A whole-line read
// or write from the cache is serviced as eight 16-bit beats (0..7 in order)
// on a word-wide SRAM-style port, then pmem_resp pulses for one cycle.
//
// Handshakes: the cache holds pmem_read/pmem_write (and address/wdata) until
// it sees pmem_resp. On the SRAM side sram_req acts as valid and sram_ack as
// ready: a beat transfers in any cycle where both are high, read data is
// taken from sram_rdata in that same cycle, and while ack is low every sram_*
// output holds steady. All outputs come from registers.
module line_mem_responder
    import cache_types::*;
#(
    // Word-address width of the backing port; must be at least 15. Bits
    // above bit 14 are always driven 0.
    parameter int SRAM_ADDR_WIDTH = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [15:0]                pmem_address,
    input  logic                       pmem_read,
    input  logic                       pmem_write,
    input  logic [127:0]               pmem_wdata,
    output logic [127:0]               pmem_rdata,
    output logic                       pmem_resp,
    output logic                       sram_req,
    output logic                       sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]                sram_wdata,
    input  logic                       sram_ack,
    input  logic [15:0]                sram_rdata,
    output logic [1:0]                 dbg_state
);

    responder_state_t state_q;
    beat_index        beat_q;
    logic [11:0]      line_addr_q;

    logic        buf_load;
    logic        buf_wr;
    beat_index   next_beat;
    logic [15:0] buf_rd_data;
    cache_line   buf_line;
    cache_line   rdata_merged;
    logic [3:0]  unused_addr_lsbs;

    // Byte offset within the line carries no information for a line transfer.
    assign unused_addr_lsbs = pmem_address[3:0];

    // Word address of a beat: line address over beat number, zero-extended.
    function automatic logic [SRAM_ADDR_WIDTH-1:0] word_addr(
        input logic [11:0] line_addr,
        input logic [2:0]  beat
    );
        word_addr       = '0;
        word_addr[14:0] = {line_addr, beat};
    endfunction

    // Load the line at acceptance (write data; harmless for reads), then
    // capture each read beat as it is acknowledged.
    assign buf_load  = (state_q == IDLE) && (pmem_read || pmem_write);
    assign buf_wr    = (state_q == BURST) && sram_ack && !sram_we;
    assign next_beat = beat_q + 3'd1;

    line_beat_buffer u_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_en   (buf_load),
        .load_data (pmem_wdata),
        .wr_en     (buf_wr),
        .wr_beat   (beat_q),
        .wr_data   (sram_rdata),
        .rd_beat   (next_beat),
        .rd_data   (buf_rd_data),
        .line_out  (buf_line)
    );

    // The last beat lands in the buffer on the same edge pmem_rdata loads,
    // so splice it in directly rather than waiting a cycle.
    always_comb begin
        rdata_merged           = buf_line;
        rdata_merged[127:112]  = sram_rdata;
    end

    // Responder FSM: accept in IDLE, walk beats 0..7 in BURST, pulse in RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            line_addr_q <= '0;
            sram_req    <= 1'b0;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            pmem_resp   <= 1'b0;
            pmem_rdata  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pmem_write || pmem_read) begin
                        // Write wins if both are asserted.
                        line_addr_q <= pmem_address[15:4];
                        sram_we     <= pmem_write;
                        beat_q      <= '0;
                        sram_req    <= 1'b1;
                        sram_addr   <= word_addr(pmem_address[15:4], 3'd0);
                        sram_wdata  <= pmem_wdata[15:0];
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    if (sram_ack) begin
                        if (beat_q == 3'd7) begin
                            sram_req  <= 1'b0;
                            pmem_resp <= 1'b1;
                            state_q   <= RESP;
                            if (!sram_we) begin
                                pmem_rdata <= rdata_merged;
                            end
                        end else begin
                            // Next beat is presented with no bubble.
                            beat_q     <= next_beat;
                            sram_addr  <= word_addr(line_addr_q, next_beat);
                            sram_wdata <= buf_rd_data;
                        end
                    end
                end
                RESP: begin
                    pmem_resp <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: zero-wait read, line write, stalled
// beat, writeback followed by fill, mid-burst reset and read+write collision.
module tb_line_mem_responder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         sram_req;
    logic         sram_we;
    logic [14:0]  sram_addr;
    logic [15:0]  sram_wdata;
    logic         sram_ack;
    logic [15:0]  sram_rdata;
    logic [1:0]   dbg_state;

    logic         ack_en;
    logic [15:0]  rd_xor;
    int           n_checks = 0;
    int           n_errors = 0;

    localparam logic [127:0] RD0_LINE = 128'h091F_091E_091D_091C_091B_091A_0919_0918;
    localparam logic [127:0] WR_LINE  = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
    localparam logic [127:0] WR_LINE2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    // SRAM model: acks when enabled, read word = word address ^ pattern.
    assign sram_ack   = sram_req & ack_en;
    assign sram_rdata = {1'b0, sram_addr} ^ rd_xor;

    always #5 clk = ~clk;

    line_mem_responder #(.SRAM_ADDR_WIDTH(15)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .sram_req     (sram_req),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_ack     (sram_ack),
        .sram_rdata   (sram_rdata),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_line(input logic [15:0] base, input logic [15:0] x);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) r[16*b +: 16] = (base + 16'(b)) ^ x;
        return r;
    endfunction

    // Drives a request in the current cycle (cycle 0), checks every beat and
    // returns in the pmem_resp cycle with the request dropped.
    task automatic run_line(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [127:0] wdata, input int hold_beat, input int hold_len,
                            input logic [127:0] exp_rdata, input string tag);
        logic [15:0] base;
        base         = {1'b0, addr[15:4], 3'b000};
        pmem_address = addr;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_wdata   = wdata;
        ack_en       = 1'b1;
        for (int b = 0; b < 8; b++) begin
            tick();
            check({tag, "_req"},  128'(sram_req), 128'(1'b1));
            check({tag, "_addr"}, 128'(sram_addr), 128'(base + 16'(b)));
            check({tag, "_we"},   128'(sram_we), 128'(wr));
            check({tag, "_resp_early"}, 128'(pmem_resp), 128'(1'b0));
            if (wr) check({tag, "_wdata"}, 128'(sram_wdata), 128'(wdata[16*b +: 16]));
            if (b == hold_beat) begin
                ack_en = 1'b0;
                for (int k = 1; k <= hold_len; k++) begin
                    tick();
                    check({tag, "_hold_req"},  128'(sram_req), 128'(1'b1));
                    check({tag, "_hold_addr"}, 128'(sram_addr), 128'(base + 16'(b)));
                    check({tag, "_hold_resp"}, 128'(pmem_resp), 128'(1'b0));
                end
                ack_en = 1'b1;
            end
        end
        tick();
        check({tag, "_resp"},     128'(pmem_resp), 128'(1'b1));
        check({tag, "_req_done"}, 128'(sram_req), 128'(1'b0));
        check({tag, "_state"},    128'(dbg_state), 128'(2'd2));
        check({tag, "_rdata"},    pmem_rdata, exp_rdata);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        ack_en       = 1'b1;
        rd_xor       = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   128'(sram_req), 128'(1'b0));
        check("rst_we",    128'(sram_we), 128'(1'b0));
        check("rst_addr",  128'(sram_addr), 128'(0));
        check("rst_wdata", 128'(sram_wdata), 128'(0));
        check("rst_resp",  128'(pmem_resp), 128'(1'b0));
        check("rst_rdata", pmem_rdata, 128'(0));
        check("rst_state", 128'(dbg_state), 128'(2'd0));
        reset_n = 1'b1;
        tick();

        // Zero-wait read: word value = word address.
        run_line(1'b1, 1'b0, 16'h1230, '0, -1, 0, RD0_LINE, "rd0");
        tick();
        check("rd0_resp_drop", 128'(pmem_resp), 128'(1'b0));
        check("rd0_idle",      128'(dbg_state), 128'(2'd0));
        check("rd0_rdata_hold", pmem_rdata, RD0_LINE);

        // Write, then fill requested in the cycle right after the write resp.
        run_line(1'b0, 1'b1, 16'h4008, WR_LINE, -1, 0, RD0_LINE, "wr");
        tick();
        check("wb_gap_resp",  128'(pmem_resp), 128'(1'b0));
        check("wb_gap_rdata", pmem_rdata, RD0_LINE);
        rd_xor = 16'h0F0F;
        run_line(1'b1, 1'b0, 16'h0560, '0, -1, 0, exp_line(16'h02B0, 16'h0F0F), "fill");

        // Read with ack withheld three cycles on beat 4.
        tick();
        run_line(1'b1, 1'b0, 16'hABC0, '0, 4, 3, exp_line(16'h55E0, 16'h0F0F), "hold");

        // Reset in the middle of beat 3 of a write.
        tick();
        pmem_address = 16'h7770;
        pmem_wdata   = WR_LINE2;
        pmem_write   = 1'b1;
        repeat (4) tick();
        check("mid_addr_b3", 128'(sram_addr), 128'(16'h3BBB));
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_req_async", 128'(sram_req), 128'(1'b0));
        check("mid_state",     128'(dbg_state), 128'(2'd0));
        check("mid_rdata",     pmem_rdata, 128'(0));
        pmem_write = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_resp", 128'(pmem_resp), 128'(1'b0));
            check("mid_no_req",  128'(sram_req), 128'(1'b0));
        end
        rd_xor = 16'h5A5A;
        run_line(1'b1, 1'b0, 16'h0020, '0, -1, 0, exp_line(16'h0010, 16'h5A5A), "fresh");

        // Read and write together: serviced as a write, one resp.
        tick();
        run_line(1'b1, 1'b1, 16'hC3D0, WR_LINE2, -1, 0, exp_line(16'h0010, 16'h5A5A), "both");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("both_single_resp", 128'(pmem_resp), 128'(1'b0));
            check("both_idle",        128'(dbg_state), 128'(2'd0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
